proc_core: RTL

16-bit, two-state (fetch/execute) processor core that sits at the DUT end of the processor interface. It drives the program counter and consumes the instruction word presented for that PC. It reports every executed instruction, register write and data-memory write as one-cycle strobes, and exposes all eight architectural registers. The core contains its own 8×16 register file and 8×16 data memory.

---
 rtl/proc_pkg.sv | 51 +++++
 rtl/proc_alu.sv | 28 ++
 rtl/proc_core.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the two-state processor core.
//   opcode_t     4-bit instruction opcodes (0xB..0xF are undefined, run as NOP)
//   state_t      FETCH / EXEC sequencer states
//   REG_EN_*     encodings of the reg_en write strobe
//   DEF_*        default widths for the core parameters
//   *_MSB/*_LSB  bit positions of the instruction fields
package proc_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_PC_W   = 8;
   localparam int DEF_NREG   = 8;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int RD_MSB   = 11;
   localparam int RD_LSB   = 9;
   localparam int RS1_MSB  = 8;
   localparam int RS1_LSB  = 6;
   localparam int RS2_MSB  = 5;
   localparam int RS2_LSB  = 3;
   localparam int IMM_MSB  = 8;
   localparam int IMM_LSB  = 0;
   localparam int MADD_MSB = 2;
   localparam int MADD_LSB = 0;
   localparam int TGT_MSB  = 7;
   localparam int TGT_LSB  = 0;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_LDI  = 4'h6,
      OP_LD   = 4'h7,
      OP_ST   = 4'h8,
      OP_JMP  = 4'h9,
      OP_BEQZ = 4'hA
   } opcode_t;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

   localparam logic [1:0] REG_EN_NONE = 2'b00;
   localparam logic [1:0] REG_EN_ALU  = 2'b01;
   localparam logic [1:0] REG_EN_LOAD = 2'b10;

endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational ALU for the register-register opcodes.
//   op      decoded opcode (ADD, SUB, AND, OR, XOR produce a result)
//   a, b    operands (R[rs1], R[rs2]); SUB computes a - b
//   result  modulo 2^DATA_W result, zero for non-ALU opcodes
module proc_alu
   import proc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  opcode_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/proc_core.sv
// proc_core: 16-bit fetch/execute core with internal 8x16 register file and
// 8x16 data memory.
//   clk, rst            clock, synchronous active-high reset
//   inst_in             instruction word for the current pc
//   pc                  fetch address
//   inst_out            instruction captured at the last FETCH edge
//   reg_data/add/en     register write report (en 01 = ALU/LDI, 10 = LD)
//   mem_data/add/en     data-memory store report
//   rf_data_0..7        live register contents
//
// state | meaning
// ------+------------------------------------------------------------
// FETCH | pc stable, inst_in captured at the edge, strobes cleared
// EXEC  | ir decoded; rf/dmem write and pc update happen at the edge
module proc_core
   import proc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_W   = DEF_PC_W,
   parameter int NREG   = DEF_NREG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] inst_in,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] inst_out,
   output logic [DATA_W-1:0] reg_data,
   output logic [1:0]        reg_en,
   output logic [2:0]        reg_add,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_en,
   output logic [2:0]        mem_add,
   output logic [DATA_W-1:0] rf_data_0,
   output logic [DATA_W-1:0] rf_data_1,
   output logic [DATA_W-1:0] rf_data_2,
   output logic [DATA_W-1:0] rf_data_3,
   output logic [DATA_W-1:0] rf_data_4,
   output logic [DATA_W-1:0] rf_data_5,
   output logic [DATA_W-1:0] rf_data_6,
   output logic [DATA_W-1:0] rf_data_7
);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] reg_data_q, reg_data_d;
   logic [1:0]        reg_en_q, reg_en_d;
   logic [2:0]        reg_add_q, reg_add_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_en_q, mem_en_d;
   logic [2:0]        mem_add_q, mem_add_d;
   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];
   logic [DATA_W-1:0] dmem_q [NREG];
   logic [DATA_W-1:0] dmem_d [NREG];

   opcode_t           op;
   logic [2:0]        rd, rs1, rs2, madd;
   logic [8:0]        imm9;
   logic [PC_W-1:0]   tgt;
   logic [DATA_W-1:0] alu_res;

   // Undefined opcodes cast to values outside the enum and fall to default.
   assign op   = opcode_t'(ir_q[OP_MSB:OP_LSB]);
   assign rd   = ir_q[RD_MSB:RD_LSB];
   assign rs1  = ir_q[RS1_MSB:RS1_LSB];
   assign rs2  = ir_q[RS2_MSB:RS2_LSB];
   assign imm9 = ir_q[IMM_MSB:IMM_LSB];
   assign madd = ir_q[MADD_MSB:MADD_LSB];
   assign tgt  = ir_q[TGT_MSB:TGT_LSB];

   proc_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op),
      .a      (rf_q[rs1]),
      .b      (rf_q[rs2]),
      .result (alu_res)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      reg_data_d = reg_data_q;
      reg_en_d   = reg_en_q;
      reg_add_d  = reg_add_q;
      mem_data_d = mem_data_q;
      mem_en_d   = mem_en_q;
      mem_add_d  = mem_add_q;
      rf_d       = rf_q;
      dmem_d     = dmem_q;
      case (state_q)
         FETCH: begin
            ir_d     = inst_in;
            reg_en_d = REG_EN_NONE;
            mem_en_d = 1'b0;
            state_d  = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            pc_d    = pc_q + PC_W'(1);
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  rf_d[rd]   = alu_res;
                  reg_data_d = alu_res;
                  reg_add_d  = rd;
                  reg_en_d   = REG_EN_ALU;
               end
               OP_LDI: begin
                  rf_d[rd]   = DATA_W'(imm9);
                  reg_data_d = DATA_W'(imm9);
                  reg_add_d  = rd;
                  reg_en_d   = REG_EN_ALU;
               end
               OP_LD: begin
                  rf_d[rd]   = dmem_q[madd];
                  reg_data_d = dmem_q[madd];
                  reg_add_d  = rd;
                  reg_en_d   = REG_EN_LOAD;
               end
               OP_ST: begin
                  dmem_d[madd] = rf_q[rd];
                  mem_data_d   = rf_q[rd];
                  mem_add_d    = madd;
                  mem_en_d     = 1'b1;
               end
               OP_JMP: pc_d = tgt;
               OP_BEQZ: begin
                  if (rf_q[rd] == '0) pc_d = tgt;
               end
               default: ;
            endcase
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= '0;
         ir_q       <= '0;
         reg_data_q <= '0;
         reg_en_q   <= REG_EN_NONE;
         reg_add_q  <= '0;
         mem_data_q <= '0;
         mem_en_q   <= 1'b0;
         mem_add_q  <= '0;
         rf_q       <= '{default: '0};
         dmem_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         reg_data_q <= reg_data_d;
         reg_en_q   <= reg_en_d;
         reg_add_q  <= reg_add_d;
         mem_data_q <= mem_data_d;
         mem_en_q   <= mem_en_d;
         mem_add_q  <= mem_add_d;
         rf_q       <= rf_d;
         dmem_q     <= dmem_d;
      end
   end

   // The instruction register is the value reported on inst_out.
   assign pc        = pc_q;
   assign inst_out  = ir_q;
   assign reg_data  = reg_data_q;
   assign reg_en    = reg_en_q;
   assign reg_add   = reg_add_q;
   assign mem_data  = mem_data_q;
   assign mem_en    = mem_en_q;
   assign mem_add   = mem_add_q;
   assign rf_data_0 = rf_q[0];
   assign rf_data_1 = rf_q[1];
   assign rf_data_2 = rf_q[2];
   assign rf_data_3 = rf_q[3];
   assign rf_data_4 = rf_q[4];
   assign rf_data_5 = rf_q[5];
   assign rf_data_6 = rf_q[6];
   assign rf_data_7 = rf_q[7];

endmodule
